// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> BUS -> DONE access sequencer with lane steering and load extension.
// Optional bus-wait timeout is built only when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   output logic [31:0] ReadData,
   output logic        stall,
   output logic        fault,
   output logic        bus_err,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state_o
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("load_store_unit: TIMEOUT_CYCLES out of range 2..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        bus_valid_q, bus_valid_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_wstrb_q, bus_wstrb_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_q, tmo_d;
   logic        bus_err_q, bus_err_d;
`endif

   logic        legal_f3;
   logic        aligned;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Legality and alignment of the access presented in IDLE.
   always_comb begin
      legal_f3 = 1'b0;
      aligned  = 1'b0;
      if (MemWrite) begin
         legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end else begin
         legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~Mem_WrAddr[0];
         2'b10:   aligned = (Mem_WrAddr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Stores replicate the datum across lanes; strobes pick the live bytes.
   always_comb begin
      st_wdata = Mem_WrData;
      st_wstrb = 4'b0000;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{Mem_WrData[7:0]}};
            st_wstrb = 4'b0001 << Mem_WrAddr[1:0];
         end
         2'b01: begin
            st_wdata = {2{Mem_WrData[15:0]}};
            st_wstrb = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = Mem_WrData;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      ld_byte = bus_rdata[7:0];
      case (off_q)
         2'b00:   ld_byte = bus_rdata[7:0];
         2'b01:   ld_byte = bus_rdata[15:8];
         2'b10:   ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_ext = bus_rdata;
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus_valid_d = bus_valid_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      fault_d     = fault_q;
`ifdef LSU_TIMEOUT_EN
      tmo_d       = tmo_q;
      bus_err_d   = bus_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            rdata_d = 32'd0;
            if (mem_req) begin
               if (legal_f3 && aligned) begin
                  bus_valid_d = 1'b1;
                  bus_we_d    = MemWrite;
                  bus_addr_d  = {Mem_WrAddr[31:2], 2'b00};
                  bus_wdata_d = MemWrite ? st_wdata : 32'd0;
                  bus_wstrb_d = MemWrite ? st_wstrb : 4'b0000;
                  funct3_d    = funct3;
                  off_d       = Mem_WrAddr[1:0];
`ifdef LSU_TIMEOUT_EN
                  tmo_d       = 16'd0;
`endif
                  state_d     = S_BUS;
               end else begin
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_BUS: begin
            // A completion in the same cycle as the timeout takes priority.
            if (bus_ready) begin
               bus_valid_d = 1'b0;
               rdata_d     = bus_we_q ? 32'd0 : ld_ext;
               state_d     = S_DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else if (tmo_q == TO_LAST) begin
               bus_valid_d = 1'b0;
               bus_err_d   = 1'b1;
               rdata_d     = 32'd0;
               state_d     = S_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
         end
         S_DONE: begin
            fault_d = 1'b0;
            rdata_d = 32'd0;
`ifdef LSU_TIMEOUT_EN
            bus_err_d = 1'b0;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_wstrb_q <= 4'b0000;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
         rdata_q     <= 32'd0;
         fault_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         tmo_q       <= 16'd0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_valid_q <= bus_valid_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
`ifdef LSU_TIMEOUT_EN
         tmo_q       <= tmo_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign stall       = mem_req & (state_q != S_DONE);
   assign ReadData    = (state_q == S_DONE) ? rdata_q : 32'd0;
   assign fault       = fault_q;
   assign bus_valid   = bus_valid_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wstrb   = bus_wstrb_q;
   assign dbg_state_o = state_q;
`ifdef LSU_TIMEOUT_EN
   assign bus_err     = bus_err_q;
`else
   assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change and outputs are sampled on the falling edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic [31:0] ReadData;
   logic        stall;
   logic        fault;
   logic        bus_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [1:0]  dbg_state_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .MemWrite    (MemWrite),
      .funct3      (funct3),
      .Mem_WrAddr  (Mem_WrAddr),
      .Mem_WrData  (Mem_WrData),
      .ReadData    (ReadData),
      .stall       (stall),
      .fault       (fault),
      .bus_err     (bus_err),
      .bus_valid   (bus_valid),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_wstrb   (bus_wstrb),
      .bus_ready   (bus_ready),
      .bus_rdata   (bus_rdata),
      .dbg_state_o (dbg_state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
      mem_req    = 1'b1;
      MemWrite   = we;
      funct3     = f3;
      Mem_WrAddr = a;
      Mem_WrData = d;
   endtask

   // Load with bus_ready high in the first BUS cycle; starts and ends in IDLE.
   task automatic load_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp_val);
      set_req(1'b0, f3, a, 32'd0);
      bus_ready = 1'b1;
      bus_rdata = rd;
      step();
      chk({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, " wstrb"}, {28'd0, bus_wstrb}, 32'd0);
      step();
      chk({tag, " ReadData"}, ReadData, exp_val);
      chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      bus_rdata = 32'd0;
      step();
   endtask

   task automatic store_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      set_req(1'b1, f3, a, d);
      bus_ready = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      step();
      chk({tag, " bus_we"}, {31'd0, bus_we}, 32'd1);
      chk({tag, " bus_valid"}, {31'd0, bus_valid}, 32'd1);
      chk({tag, " bus_addr"}, bus_addr, exp_addr);
      chk({tag, " wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_strb});
      chk({tag, " wdata"}, bus_wdata, exp_wdata);
      step();
      chk({tag, " ReadData"}, ReadData, 32'd0);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      step();
   endtask

   // Illegal or misaligned access: straight to DONE, no bus cycle.
   task automatic fault_req(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a);
      set_req(we, f3, a, 32'h1234_5678);
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      step();
      chk({tag, " state"}, {30'd0, dbg_state_o}, 32'd2);
      chk({tag, " fault"}, {31'd0, fault}, 32'd1);
      chk({tag, " bus_valid"}, {31'd0, bus_valid}, 32'd0);
      chk({tag, " ReadData"}, ReadData, 32'd0);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      step();
      chk({tag, " fault_clr"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_cnt;
      int waited;
      reset      = 1'b0;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      funct3     = 3'd0;
      Mem_WrAddr = 32'd0;
      Mem_WrData = 32'd0;
      bus_ready  = 1'b0;
      bus_rdata  = 32'd0;
      step();
      step();
      chk("rst state", {30'd0, dbg_state_o}, 32'd0);
      chk("rst bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst bus_wdata", bus_wdata, 32'd0);
      chk("rst wstrb", {28'd0, bus_wstrb}, 32'd0);
      chk("rst ReadData", ReadData, 32'd0);
      chk("rst fault", {31'd0, fault}, 32'd0);
      chk("rst bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst stall", {31'd0, stall}, 32'd0);
      reset = 1'b1;
      step();

      // LW with immediate ready, cycle by cycle.
      set_req(1'b0, 3'b010, 32'h0000_1004, 32'd0);
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      #1;
      chk("lw c1 stall", {31'd0, stall}, 32'd1);
      chk("lw c1 bus_valid", {31'd0, bus_valid}, 32'd0);
      step();
      chk("lw c2 state", {30'd0, dbg_state_o}, 32'd1);
      chk("lw c2 bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("lw c2 bus_addr", bus_addr, 32'h0000_1004);
      chk("lw c2 wstrb", {28'd0, bus_wstrb}, 32'd0);
      chk("lw c2 stall", {31'd0, stall}, 32'd1);
      chk("lw c2 ReadData", ReadData, 32'd0);
      step();
      chk("lw c3 ReadData", ReadData, 32'hDEAD_BEEF);
      chk("lw c3 stall", {31'd0, stall}, 32'd0);
      chk("lw c3 bus_valid", {31'd0, bus_valid}, 32'd0);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      step();
      chk("lw c4 state", {30'd0, dbg_state_o}, 32'd0);
      chk("lw c4 ReadData", ReadData, 32'd0);

      load_imm("lb", 3'b000, 32'h0000_2003, 32'h8000_0000, 32'hFFFF_FF80);
      load_imm("lbu", 3'b100, 32'h0000_2003, 32'h8000_0000, 32'h0000_0080);
      load_imm("lhu hi", 3'b101, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
      load_imm("lh lo", 3'b001, 32'h0000_2000, 32'h0000_8765, 32'hFFFF_8765);
      load_imm("lb b1", 3'b000, 32'h0000_2001, 32'h0000_7F00, 32'h0000_007F);

      store_imm("sb", 3'b000, 32'h0000_3002, 32'h0000_00A5, 32'h0000_3000, 4'b0100, 32'hA5A5_A5A5);
      store_imm("sh", 3'b001, 32'h0000_3002, 32'hCAFE_1234, 32'h0000_3000, 4'b1100, 32'h1234_1234);
      store_imm("sw", 3'b010, 32'h0000_3004, 32'h1122_3344, 32'h0000_3004, 4'b1111, 32'h1122_3344);

      fault_req("sw misalign", 1'b1, 3'b010, 32'h0000_3002);
      fault_req("lh misalign", 1'b0, 3'b001, 32'h0000_1001);
      fault_req("load f3 011", 1'b0, 3'b011, 32'h0000_1000);
      fault_req("store f3 100", 1'b1, 3'b100, 32'h0000_1000);

      // LH with bus_ready arriving in the fifth BUS cycle.
      set_req(1'b0, 3'b001, 32'h0000_4002, 32'd0);
      bus_ready = 1'b0;
      bus_rdata = 32'h8001_0000;
      stall_cnt = 0;
      #1;
      if (stall) stall_cnt++;
      for (int i = 0; i < 5; i++) begin
         step();
         if (stall) stall_cnt++;
         chk("lh wait bus_valid", {31'd0, bus_valid}, 32'd1);
         chk("lh wait bus_addr", bus_addr, 32'h0000_4000);
         if (i == 4) bus_ready = 1'b1;
      end
      step();
      chk("lh wait ReadData", ReadData, 32'hFFFF_8001);
      chk("lh wait stall_cnt", stall_cnt, 32'd6);
      chk("lh wait bus_err", {31'd0, bus_err}, 32'd0);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      step();

      // Back-to-back: a request held through DONE is taken only from IDLE.
      set_req(1'b0, 3'b010, 32'h0000_5000, 32'd0);
      bus_ready = 1'b1;
      bus_rdata = 32'h0000_AB00;
      step();
      step();
      chk("b2b first ReadData", ReadData, 32'h0000_AB00);
      set_req(1'b0, 3'b100, 32'h0000_5001, 32'd0);
      step();
      chk("b2b idle state", {30'd0, dbg_state_o}, 32'd0);
      chk("b2b idle stall", {31'd0, stall}, 32'd1);
      step();
      chk("b2b second bus_addr", bus_addr, 32'h0000_5000);
      step();
      chk("b2b second ReadData", ReadData, 32'h0000_00AB);
      mem_req   = 1'b0;
      bus_ready = 1'b0;
      step();

      // Reset while waiting in BUS.
      set_req(1'b0, 3'b010, 32'h0000_6000, 32'd0);
      bus_ready = 1'b0;
      step();
      chk("rst bus pre bus_valid", {31'd0, bus_valid}, 32'd1);
      reset = 1'b0;
      step();
      chk("rst bus state", {30'd0, dbg_state_o}, 32'd0);
      chk("rst bus bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst bus stall", {31'd0, stall}, 32'd1);
      chk("rst bus ReadData", ReadData, 32'd0);
      reset   = 1'b1;
      mem_req = 1'b0;
      #1;
      chk("rst bus stall off", {31'd0, stall}, 32'd0);
      step();

`ifdef LSU_TIMEOUT_EN
      // Bus never answers: with TIMEOUT_CYCLES=8 the eighth BUS cycle ends the access.
      set_req(1'b0, 3'b010, 32'h0000_7000, 32'd0);
      bus_ready = 1'b0;
      bus_rdata = 32'hFFFF_FFFF;
      waited = 0;
      while (dbg_state_o != 2'd2 && waited < 20) begin
         step();
         waited++;
      end
      chk("tmo cycles", waited, 32'd9);
      chk("tmo bus_err", {31'd0, bus_err}, 32'd1);
      chk("tmo ReadData", ReadData, 32'd0);
      chk("tmo fault", {31'd0, fault}, 32'd0);
      mem_req = 1'b0;
      step();
      chk("tmo bus_err clr", {31'd0, bus_err}, 32'd0);
`else
      waited = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
